// File: rtl/y_demux1to4_reg_pkg.sv
// ---------------------------------------------------------------------------
// y_demux1to4_reg_pkg
// Shared definitions for the registered 1-to-4 demultiplexer:
//   LANES / SEL_W       lane count and select width
//   LANE0..LANE3        lane index constants used by the select decode
//   DEF_SIZE/DEF_CNT_W  default data and delivery-counter widths
//   lane_rec_t          lane record (valid + data) at the default width
// ---------------------------------------------------------------------------
package y_demux1to4_reg_pkg;

    localparam int LANES     = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_SIZE  = 32;
    localparam int DEF_CNT_W = 8;

    localparam logic [SEL_W-1:0] LANE0 = 2'd0;
    localparam logic [SEL_W-1:0] LANE1 = 2'd1;
    localparam logic [SEL_W-1:0] LANE2 = 2'd2;
    localparam logic [SEL_W-1:0] LANE3 = 2'd3;

    // A package typedef cannot take a module parameter, so the lane
    // sub-module re-declares this record with its own SIZE; this one
    // documents the layout and serves default-width users.
    typedef struct packed {
        logic                valid;
        logic [DEF_SIZE-1:0] data;
    } lane_rec_t;

endpackage : y_demux1to4_reg_pkg

// File: rtl/y_demux_lane.sv
// ---------------------------------------------------------------------------
// y_demux_lane
// One-entry register slice for a single demux output lane.
//   clk, rst_n   clock, synchronous active-low reset
//   load         write load_data into the slice this cycle
//   load_data    word to capture
//   take         consumer takes the held word this cycle
//   lane_ready   slice can accept a word this cycle (empty or draining)
//   valid, data  registered lane contents
//   cnt          wrapping count of words delivered from this lane
// ---------------------------------------------------------------------------
module y_demux_lane
    import y_demux1to4_reg_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SIZE-1:0]  load_data,
    input  logic             take,
    output logic             lane_ready,
    output logic             valid,
    output logic [SIZE-1:0]  data,
    output logic [CNT_W-1:0] cnt
);

    typedef struct packed {
        logic            valid;
        logic [SIZE-1:0] data;
    } rec_t;

    rec_t             rec_r;
    rec_t             rec_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             deliver_s;
    logic             accept_s;

    // Next-state for the holding register and the delivery counter.
    always_comb begin
        rec_s     = rec_r;
        cnt_s     = cnt_r;
        deliver_s = rec_r.valid & take;
        // A load is only honoured when the slice has room, so a stalled
        // word can never be overwritten even if the caller misbehaves.
        accept_s  = load & ((~rec_r.valid) | take);
        if (accept_s) begin
            rec_s.valid = 1'b1;
            rec_s.data  = load_data;
        end else if (deliver_s) begin
            rec_s.valid = 1'b0;
        end else begin
            rec_s.valid = rec_r.valid;
        end
        if (deliver_s) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Lane state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rec_r <= '0;
            cnt_r <= '0;
        end else begin
            rec_r <= rec_s;
            cnt_r <= cnt_s;
        end
    end

    assign lane_ready = (~rec_r.valid) | take;
    assign valid      = rec_r.valid;
    assign data       = rec_r.data;
    assign cnt        = cnt_r;

endmodule : y_demux_lane

// File: rtl/y_demux1to4_reg.sv
// ---------------------------------------------------------------------------
// y_demux1to4_reg
// Registered 1-to-4 demultiplexer: one producer word per handshake is
// routed by in_sel into one of four independent one-entry lanes.
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       producer handshake (in_ready combinational)
//   in_data, in_sel         word and destination lane
//   out_valid[3:0]          lane k holds a word
//   out_ready[3:0]          consumer k takes lane k
//   out_data0..out_data3    lane data registers
//   cnt0..cnt3              wrapping per-lane delivery counters
//   busy                    any lane holds a word
// ---------------------------------------------------------------------------
module y_demux1to4_reg
    import y_demux1to4_reg_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic [SIZE-1:0]  out_data0,
    output logic [SIZE-1:0]  out_data1,
    output logic [SIZE-1:0]  out_data2,
    output logic [SIZE-1:0]  out_data3,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic             busy
);

    logic [LANES-1:0] lane_ready_s;
    logic [LANES-1:0] load_s;
    logic [SIZE-1:0]  lane_data_s [LANES];
    logic [CNT_W-1:0] lane_cnt_s  [LANES];

    // in_ready follows only the selected lane and is held low during reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (in_sel)
                LANE0:   in_ready = lane_ready_s[0];
                LANE1:   in_ready = lane_ready_s[1];
                LANE2:   in_ready = lane_ready_s[2];
                LANE3:   in_ready = lane_ready_s[3];
                default: in_ready = 1'b0;
            endcase
        end else begin
            in_ready = 1'b0;
        end
    end

    // One-hot load strobe for the lane that accepts this cycle.
    always_comb begin
        load_s = 4'b0000;
        if (in_valid && in_ready) begin
            case (in_sel)
                LANE0:   load_s = 4'b0001;
                LANE1:   load_s = 4'b0010;
                LANE2:   load_s = 4'b0100;
                LANE3:   load_s = 4'b1000;
                default: load_s = 4'b0000;
            endcase
        end else begin
            load_s = 4'b0000;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        y_demux_lane #(
            .SIZE  (SIZE),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load_s[k]),
            .load_data  (in_data),
            .take       (out_ready[k]),
            .lane_ready (lane_ready_s[k]),
            .valid      (out_valid[k]),
            .data       (lane_data_s[k]),
            .cnt        (lane_cnt_s[k])
        );
    end

    assign out_data0 = lane_data_s[0];
    assign out_data1 = lane_data_s[1];
    assign out_data2 = lane_data_s[2];
    assign out_data3 = lane_data_s[3];
    assign cnt0      = lane_cnt_s[0];
    assign cnt1      = lane_cnt_s[1];
    assign cnt2      = lane_cnt_s[2];
    assign cnt3      = lane_cnt_s[3];
    assign busy      = |out_valid;

endmodule : y_demux1to4_reg
